decode_issue: RTL and testbench

- Decode/issue stage of the processor pipeline, sitting between fetch and the execute ALU.
- Accepts one 32-bit instruction per cycle from fetch and decodes its fields.
- Reads the register file and checks a register scoreboard for pending writes.
- Presents opcode, data1, data2, store data and destination to execute through a registered valid/ready stage; writeback returns results into the register file.

---
 rtl/decode_issue_pkg.sv | 49 ++++
 rtl/decode_regfile.sv | 30 +++
 rtl/decode_issue.sv | 138 +++++++++++++
 tb/tb_decode_issue.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_pkg.sv
// rtl/decode_issue_pkg.sv - proc constants: widths, opcodes, instruction field positions
// Shared by decode_issue and decode_regfile.
package decode_issue_pkg;

   localparam int ARCH_BITS    = 32;
   localparam int NREGS        = 32;
   localparam int REG_IDX_BITS = 5;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 25;
   localparam int RD_HI  = 24;
   localparam int RD_LO  = 20;
   localparam int RA_HI  = 19;
   localparam int RA_LO  = 15;
   localparam int RB_HI  = 14;
   localparam int RB_LO  = 10;
   localparam int IMM_W  = 15;

   localparam logic [6:0] OP_ADD  = 7'h01;
   localparam logic [6:0] OP_SUB  = 7'h02;
   localparam logic [6:0] OP_LDB  = 7'h03;
   localparam logic [6:0] OP_LDW  = 7'h04;
   localparam logic [6:0] OP_STB  = 7'h05;
   localparam logic [6:0] OP_STW  = 7'h06;
   localparam logic [6:0] OP_BEQ  = 7'h07;
   localparam logic [6:0] OP_BZ   = 7'h08;
   localparam logic [6:0] OP_JUMP = 7'h09;
   localparam logic [6:0] OP_MOV  = 7'h0a;
   localparam logic [6:0] OP_MOVI = 7'h0b;

   typedef struct packed {
      logic [6:0]              opcode;
      logic [REG_IDX_BITS-1:0] rd;
      logic [REG_IDX_BITS-1:0] ra;
      logic [REG_IDX_BITS-1:0] rb;
      logic [ARCH_BITS-1:0]    imm;
   } fields_t;

   function automatic fields_t split_instr(input logic [ARCH_BITS-1:0] instr);
      fields_t f;
      f.opcode = instr[OPC_HI:OPC_LO];
      f.rd     = instr[RD_HI:RD_LO];
      f.ra     = instr[RA_HI:RA_LO];
      f.rb     = instr[RB_HI:RB_LO];
      f.imm    = {{(ARCH_BITS-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
      return f;
   endfunction

endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - register file, two async read ports, one sync write port
// r0 reads zero and ignores writes.
module decode_regfile
   import decode_issue_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [REG_IDX_BITS-1:0] waddr,
   input  logic [ARCH_BITS-1:0]    wdata,
   input  logic [REG_IDX_BITS-1:0] raddr_a,
   output logic [ARCH_BITS-1:0]    rdata_a,
   input  logic [REG_IDX_BITS-1:0] raddr_b,
   output logic [ARCH_BITS-1:0]    rdata_b
);

   logic [ARCH_BITS-1:0] regs [NREGS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode/issue stage: field decode, scoreboard, registered ex payload
// Optional DECODE_BYPASS_EN forwards same-cycle writeback into the operand mux.
module decode_issue
   import decode_issue_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_valid,
   output logic                    if_ready,
   input  logic [ARCH_BITS-1:0]    if_instr,
   input  logic [ARCH_BITS-1:0]    if_pc,
   output logic                    ex_valid,
   input  logic                    ex_ready,
   output logic [6:0]              ex_opcode,
   output logic [ARCH_BITS-1:0]    ex_data1,
   output logic [ARCH_BITS-1:0]    ex_data2,
   output logic [ARCH_BITS-1:0]    ex_store_data,
   output logic [REG_IDX_BITS-1:0] ex_rd,
   output logic                    ex_wb_en,
   output logic                    ex_illegal,
   input  logic                    wb_en,
   input  logic [REG_IDX_BITS-1:0] wb_rd,
   input  logic [ARCH_BITS-1:0]    wb_data,
   input  logic                    flush
);

   fields_t              f;
   logic [ARCH_BITS-1:0] rf_a, rf_b, op_a, op_b;
   logic [ARCH_BITS-1:0] d_data1, d_data2, d_store;
   logic                 d_wb, d_ill, use_a, use_b;
   logic                 fwd_a, fwd_b, hazard, accept;
   logic [NREGS-1:0]     busy, busy_n;

   assign f = split_instr(if_instr);

   decode_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (wb_en),
      .waddr   (wb_rd),
      .wdata   (wb_data),
      .raddr_a (f.ra),
      .rdata_a (rf_a),
      .raddr_b (f.rb),
      .rdata_b (rf_b)
   );

`ifdef DECODE_BYPASS_EN
   assign fwd_a = wb_en && (wb_rd == f.ra) && (f.ra != '0);
   assign fwd_b = wb_en && (wb_rd == f.rb) && (f.rb != '0);
`else
   assign fwd_a = 1'b0;
   assign fwd_b = 1'b0;
`endif

   assign op_a = fwd_a ? wb_data : rf_a;
   assign op_b = fwd_b ? wb_data : rf_b;

   always_comb begin
      d_data1 = '0;
      d_data2 = '0;
      d_store = '0;
      d_wb    = 1'b0;
      d_ill   = 1'b0;
      use_a   = 1'b0;
      use_b   = 1'b0;
      case (f.opcode)
         OP_ADD, OP_SUB: begin
            d_data1 = op_a; d_data2 = op_b; d_wb = 1'b1; use_a = 1'b1; use_b = 1'b1;
         end
         OP_LDB, OP_LDW: begin
            d_data1 = op_a; d_data2 = f.imm; d_wb = 1'b1; use_a = 1'b1;
         end
         OP_STB, OP_STW: begin
            d_data1 = op_a; d_data2 = f.imm; d_store = op_b; use_a = 1'b1; use_b = 1'b1;
         end
         OP_BEQ: begin
            d_data1 = if_pc; d_data2 = f.imm; d_store = op_b; use_a = 1'b1; use_b = 1'b1;
         end
         // BZ carries R[ra] for the zero test in execute
         OP_BZ: begin
            d_data1 = if_pc; d_data2 = f.imm; d_store = op_a; use_a = 1'b1;
         end
         OP_JUMP: begin
            d_data1 = op_a; d_data2 = f.imm; use_a = 1'b1;
         end
         OP_MOV: begin
            d_data1 = op_a; d_wb = 1'b1; use_a = 1'b1;
         end
         OP_MOVI: begin
            d_data1 = f.imm; d_wb = 1'b1;
         end
         default: d_ill = 1'b1;
      endcase
   end

   assign hazard   = (use_a && busy[f.ra] && !fwd_a) || (use_b && busy[f.rb] && !fwd_b);
   assign if_ready = !flush && (!ex_valid || ex_ready) && !hazard;
   assign accept   = if_valid && if_ready;

   // Order matters: wb clear, then flush clear, then accept set wins.
   always_comb begin
      busy_n = busy;
      if (wb_en) busy_n[wb_rd] = 1'b0;
      if (flush && ex_valid && ex_wb_en) busy_n[ex_rd] = 1'b0;
      if (accept && d_wb && f.rd != '0) busy_n[f.rd] = 1'b1;
      busy_n[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy          <= '0;
         ex_valid      <= 1'b0;
         ex_opcode     <= '0;
         ex_data1      <= '0;
         ex_data2      <= '0;
         ex_store_data <= '0;
         ex_rd         <= '0;
         ex_wb_en      <= 1'b0;
         ex_illegal    <= 1'b0;
      end else begin
         busy <= busy_n;
         if (accept) begin
            ex_valid      <= 1'b1;
            ex_opcode     <= f.opcode;
            ex_data1      <= d_data1;
            ex_data2      <= d_data2;
            ex_store_data <= d_store;
            ex_rd         <= f.rd;
            ex_wb_en      <= d_wb;
            ex_illegal    <= d_ill;
         end else if (flush || ex_ready) begin
            ex_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - self-checking bench for decode_issue (vector table, sequences, random vs model)
module tb_decode_issue;
   import decode_issue_pkg::*;

`ifdef DECODE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam logic [31:0] IDLE = {OP_MOVI, 25'd0};

   logic        clk = 1'b0, rst = 1'b0;
   logic        if_valid, if_ready, ex_valid, ex_ready, ex_wb_en, ex_illegal, wb_en, flush;
   logic [31:0] if_instr, if_pc, ex_data1, ex_data2, ex_store_data, wb_data;
   logic [6:0]  ex_opcode;
   logic [4:0]  ex_rd, wb_rd;

   int total = 0, bad = 0;

   decode_issue dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
      .if_pc(if_pc), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
      .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_wb_en(ex_wb_en), .ex_illegal(ex_illegal), .wb_en(wb_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rr(input logic [6:0] op, input logic [4:0] rd, ra, rb);
      return {op, rd, ra, rb, 10'd0};
   endfunction

   function automatic logic [31:0] ri(input logic [6:0] op, input logic [4:0] rd, ra,
                                      input logic [14:0] imm);
      return {op, rd, ra, imm};
   endfunction

   function automatic logic [31:0] rv(input int i);
      return 32'hA500_0000 + 32'(i) * 32'h0101;
   endfunction

   function automatic logic [6:0] pick_op(input int k);
      case (k)
         0: return OP_ADD;   1: return OP_SUB;   2: return OP_LDB;  3: return OP_LDW;
         4: return OP_STB;   5: return OP_STW;   6: return OP_BEQ;  7: return OP_BZ;
         8: return OP_JUMP;  9: return OP_MOV;  10: return OP_MOVI;
         default: return 7'h7f;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b0; if_valid = 1'b0; if_instr = IDLE; if_pc = '0; ex_ready = 1'b1;
      flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
      #3 rst = 1'b1;
      tick();
   endtask

   task automatic preload();
      for (int i = 1; i < 8; i++) begin
         wb_en = 1'b1; wb_rd = 5'(i); wb_data = rv(i);
         tick();
      end
      wb_en = 1'b0;
   endtask

   // behavioural reference model state
   typedef struct {
      logic [6:0] op; logic [4:0] rd; logic [31:0] d1, d2, st; logic wb, ill;
   } pay_t;
   logic [31:0] m_regs [32];
   bit          m_busy [32];
   bit          m_valid;
   pay_t        m_p;
   logic [4:0]  wbq [$];

   function automatic logic [31:0] mread(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (BYP && wb_en && wb_rd == r) return wb_data;
      return m_regs[r];
   endfunction

   function automatic bit mbusy(input logic [4:0] r);
      return m_busy[r] && !(BYP && wb_en && wb_rd == r);
   endfunction

   task automatic mdecode(input logic [31:0] ins, input logic [31:0] pc, output pay_t p, output bit hz);
      logic [4:0]  ra, rb;
      logic [31:0] imm;
      bit          ua, ub;
      ra = ins[19:15]; rb = ins[14:10]; ua = 1'b0; ub = 1'b0;
      imm = ins[14] ? 32'(ins[14:0]) - 32'h8000 : 32'(ins[14:0]);
      p.op = ins[31:25]; p.rd = ins[24:20];
      p.d1 = '0; p.d2 = '0; p.st = '0; p.wb = 1'b0; p.ill = 1'b0;
      case (p.op)
         OP_ADD, OP_SUB: begin p.d1 = mread(ra); p.d2 = mread(rb); p.wb = 1; ua = 1; ub = 1; end
         OP_LDB, OP_LDW: begin p.d1 = mread(ra); p.d2 = imm; p.wb = 1; ua = 1; end
         OP_STB, OP_STW: begin p.d1 = mread(ra); p.d2 = imm; p.st = mread(rb); ua = 1; ub = 1; end
         OP_BEQ:         begin p.d1 = pc; p.d2 = imm; p.st = mread(rb); ua = 1; ub = 1; end
         OP_BZ:          begin p.d1 = pc; p.d2 = imm; p.st = mread(ra); ua = 1; end
         OP_JUMP:        begin p.d1 = mread(ra); p.d2 = imm; ua = 1; end
         OP_MOV:         begin p.d1 = mread(ra); p.wb = 1; ua = 1; end
         OP_MOVI:        begin p.d1 = imm; p.wb = 1; end
         default:        p.ill = 1'b1;
      endcase
      hz = (ua && mbusy(ra)) || (ub && mbusy(rb));
   endtask

   typedef struct { logic [31:0] instr, pc, d1, d2, st; logic wb, ill; } vec_t;
   vec_t tv [13];

   initial begin
      int   at;
      pay_t np;
      bit   hz, eready, acc;

      rst = 1'b0; if_valid = 1'b0; if_instr = IDLE; if_pc = '0; ex_ready = 1'b1;
      flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
      #2;
      chk1("rst_ex_valid", ex_valid, 1'b0);
      chk32("rst_ex_data1", ex_data1, 32'd0);
      chk32("rst_ex_opcode", 32'(ex_opcode), 32'd0);
      chk1("rst_ex_wb_en", ex_wb_en, 1'b0);
      #1 rst = 1'b1;
      tick();
      chk1("rst_if_ready", if_ready, 1'b1);

      // ---- table-driven single instructions ----
      tv[0]  = '{rr(OP_ADD, 16, 1, 2), 32'h0, rv(1), rv(2), 32'h0, 1'b1, 1'b0};
      tv[1]  = '{rr(OP_SUB, 17, 3, 4), 32'h0, rv(3), rv(4), 32'h0, 1'b1, 1'b0};
      tv[2]  = '{ri(OP_LDB, 18, 5, 15'h0010), 32'h0, rv(5), 32'h10, 32'h0, 1'b1, 1'b0};
      tv[3]  = '{ri(OP_LDW, 19, 6, 15'h7ffc), 32'h0, rv(6), 32'hfffffffc, 32'h0, 1'b1, 1'b0};
      tv[4]  = '{ri(OP_STB, 20, 7, 15'h0405), 32'h0, rv(7), 32'h405, rv(1), 1'b0, 1'b0};
      tv[5]  = '{ri(OP_BEQ, 21, 2, 15'h0ff0), 32'h100, 32'h100, 32'hff0, rv(3), 1'b0, 1'b0};
      tv[6]  = '{ri(OP_BZ, 22, 4, 15'h4000), 32'h2000, 32'h2000, 32'hffffc000, rv(4), 1'b0, 1'b0};
      tv[7]  = '{ri(OP_JUMP, 23, 5, 15'h0123), 32'h0, rv(5), 32'h123, 32'h0, 1'b0, 1'b0};
      tv[8]  = '{rr(OP_MOV, 24, 6, 0), 32'h0, rv(6), 32'h0, 32'h0, 1'b1, 1'b0};
      tv[9]  = '{ri(OP_MOVI, 25, 3, 15'h7fff), 32'h0, 32'hffffffff, 32'h0, 32'h0, 1'b1, 1'b0};
      tv[10] = '{rr(7'h7f, 8, 1, 2), 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
      tv[11] = '{rr(OP_ADD, 26, 8, 3), 32'h0, 32'h0, rv(3), 32'h0, 1'b1, 1'b0};
      tv[12] = '{rr(OP_ADD, 27, 0, 1), 32'h0, 32'h0, rv(1), 32'h0, 1'b1, 1'b0};
      preload();
      for (int i = 0; i < 13; i++) begin
         if_valid = 1'b1; if_instr = tv[i].instr; if_pc = tv[i].pc;
         #1 chk1($sformatf("tv%0d_if_ready", i), if_ready, 1'b1);
         tick();
         if_valid = 1'b0;
         chk1($sformatf("tv%0d_ex_valid", i), ex_valid, 1'b1);
         chk32($sformatf("tv%0d_opcode", i), 32'(ex_opcode), 32'(tv[i].instr[31:25]));
         chk32($sformatf("tv%0d_rd", i), 32'(ex_rd), 32'(tv[i].instr[24:20]));
         chk32($sformatf("tv%0d_data1", i), ex_data1, tv[i].d1);
         chk32($sformatf("tv%0d_data2", i), ex_data2, tv[i].d2);
         chk32($sformatf("tv%0d_store", i), ex_store_data, tv[i].st);
         chk1($sformatf("tv%0d_wb_en", i), ex_wb_en, tv[i].wb);
         chk1($sformatf("tv%0d_illegal", i), ex_illegal, tv[i].ill);
      end

      // ---- MOVI r1,5 then ADD r2,r1,r1 with wb on cycle 3 ----
      do_reset();
      preload();
      if_valid = 1'b1; if_instr = ri(OP_MOVI, 1, 0, 15'd5);
      #1 chk1("a_movi_ready", if_ready, 1'b1);
      tick();
      if_instr = rr(OP_ADD, 2, 1, 1);
      at = -1;
      for (int c = 1; c <= 8; c++) begin
         wb_en = (c == 3); wb_rd = 5'd1; wb_data = 32'd5;
         #1;
         if (if_ready) at = c;
         tick();
         if (at != -1) break;
      end
      wb_en = 1'b0; if_valid = 1'b0;
      chk32("a_issue_cycle", 32'(at), BYP ? 32'd3 : 32'd4);
      chk32("a_opcode", 32'(ex_opcode), 32'(OP_ADD));
      chk32("a_data1", ex_data1, 32'd5);
      chk32("a_data2", ex_data2, 32'd5);

      // ---- LDW held with ex_ready low for 4 cycles ----
      if_valid = 1'b1; if_instr = ri(OP_LDW, 3, 4, 15'h7ff8); ex_ready = 1'b1;
      #1 chk1("b_ldw_ready", if_ready, 1'b1);
      tick();
      ex_ready = 1'b0; if_instr = ri(OP_MOVI, 9, 0, 15'd7);
      for (int c = 0; c < 4; c++) begin
         chk1("b_hold_valid", ex_valid, 1'b1);
         chk32("b_hold_data1", ex_data1, rv(4));
         chk32("b_hold_data2", ex_data2, 32'hfffffff8);
         #1 chk1("b_hold_ready", if_ready, 1'b0);
         tick();
      end
      ex_ready = 1'b1;
      #1 chk1("b_release_ready", if_ready, 1'b1);
      tick();
      chk32("b_next_opcode", 32'(ex_opcode), 32'(OP_MOVI));
      chk32("b_next_data1", ex_data1, 32'd7);

      // ---- STW r5,(ra=r0),rb=r6 then ADD reading r5 ----
      if_instr = {OP_STW, 5'd5, 5'd0, 5'd6, 10'd12};
      #1 chk1("c_stw_ready", if_ready, 1'b1);
      tick();
      chk1("c_stw_wb_en", ex_wb_en, 1'b0);
      chk32("c_stw_store", ex_store_data, rv(6));
      chk32("c_stw_data2", ex_data2, 32'h0000180c);
      if_instr = rr(OP_ADD, 10, 5, 5);
      #1 chk1("c_add_no_stall", if_ready, 1'b1);
      tick();
      chk32("c_add_data1", ex_data1, rv(5));

      // ---- flush while MOV r7,r1 is held ----
      if_instr = rr(OP_MOV, 7, 1, 0);
      #1 tick();
      ex_ready = 1'b0; flush = 1'b1; if_instr = rr(OP_ADD, 8, 7, 0);
      chk1("d_mov_held", ex_valid, 1'b1);
      #1 chk1("d_flush_ready", if_ready, 1'b0);
      tick();
      flush = 1'b0;
      chk1("d_valid_after_flush", ex_valid, 1'b0);
      #1 chk1("d_add_ready", if_ready, 1'b1);
      tick();
      if_valid = 1'b0; ex_ready = 1'b1;
      chk1("d_add_valid", ex_valid, 1'b1);
      chk32("d_add_data1", ex_data1, rv(7));

      // ---- reset pulsed mid-stall ----
      do_reset();
      preload();
      if_valid = 1'b1; if_instr = ri(OP_MOVI, 1, 0, 15'h55);
      #1 tick();
      ex_ready = 1'b0; if_instr = rr(OP_ADD, 2, 1, 1);
      #1 chk1("e_stall", if_ready, 1'b0);
      tick();
      rst = 1'b0;
      #1 chk1("e_rst_valid", ex_valid, 1'b0);
      chk32("e_rst_data1", ex_data1, 32'd0);
      #1 rst = 1'b1;
      #1 chk1("e_ready_after_rst", if_ready, 1'b1);
      tick();
      chk1("e_add_valid", ex_valid, 1'b1);
      chk32("e_r1_zero", ex_data1, 32'd0);

      // ---- randomized run against the model ----
      do_reset();
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
      m_valid = 1'b0;
      wbq.delete();
      for (int c = 0; c < 400; c++) begin
         chk1("rnd_ex_valid", ex_valid, m_valid);
         if (m_valid) begin
            chk32("rnd_opcode", 32'(ex_opcode), 32'(m_p.op));
            chk32("rnd_rd", 32'(ex_rd), 32'(m_p.rd));
            chk32("rnd_data1", ex_data1, m_p.d1);
            chk32("rnd_data2", ex_data2, m_p.d2);
            chk32("rnd_store", ex_store_data, m_p.st);
            chk1("rnd_wb_en", ex_wb_en, m_p.wb);
            chk1("rnd_illegal", ex_illegal, m_p.ill);
         end
         if_valid = ($urandom_range(3) != 0);
         if_instr = {pick_op(int'($urandom_range(11))), 5'($urandom_range(7)),
                     5'($urandom_range(7)), 5'($urandom_range(7)), 10'($urandom)};
         if_pc    = $urandom;
         ex_ready = ($urandom_range(2) != 0);
         flush    = ($urandom_range(15) == 0);
         wb_en = 1'b0; wb_rd = '0; wb_data = '0;
         if (wbq.size() != 0 && $urandom_range(1) == 1) begin
            wb_en = 1'b1; wb_rd = wbq.pop_front(); wb_data = $urandom;
         end
         #1;
         mdecode(if_instr, if_pc, np, hz);
         eready = !flush && (!m_valid || ex_ready) && !hz;
         chk1("rnd_if_ready", if_ready, eready);
         acc = if_valid && eready;
         if (m_valid && ex_ready && !flush && m_p.wb && m_p.rd != 0) wbq.push_back(m_p.rd);
         if (wb_en) begin
            if (wb_rd != 0) m_regs[wb_rd] = wb_data;
            m_busy[wb_rd] = 1'b0;
         end
         if (flush && m_valid && m_p.wb) m_busy[m_p.rd] = 1'b0;
         if (acc) begin
            if (np.wb && np.rd != 0) m_busy[np.rd] = 1'b1;
            m_p = np;
            m_valid = 1'b1;
         end else if (flush || ex_ready) begin
            m_valid = 1'b0;
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
